// File: rtl/rv_pkg.sv
// Shared RISC-V encodings and 2-bit branch counter helpers for the fetch stage.
package rv_pkg;

  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [2:0]  F3_BEQ     = 3'b000;
  localparam logic [2:0]  F3_BNE     = 3'b001;
  localparam logic [31:0] NOP_INS    = 32'h0000_0013;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    if (taken) begin
      res = (ctr == 2'b11) ? 2'b11 : ctr + 2'd1;
    end else begin
      res = (ctr == 2'b00) ? 2'b00 : ctr - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/if_bpred_stage_bht.sv
// Branch history table: one 2-bit saturating counter per entry, read combinationally.
module bht
  import rv_pkg::*;
#(
  parameter int BHT_DEPTH = 16,
  parameter int BHT_IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BHT_IDX_W-1:0] rd_idx,
  output logic [1:0]           rd_ctr,
  input  logic                 upd_en,
  input  logic [BHT_IDX_W-1:0] upd_idx,
  input  logic                 upd_taken
);

  logic [1:0] ctr_q [BHT_DEPTH];

  // Read returns the stored value, so a same-cycle update is seen only next cycle.
  assign rd_ctr = ctr_q[rd_idx];

  // Counter storage: reset to weakly not-taken, saturating update on request.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        ctr_q[i] <= WNT;
      end
    end else if (upd_en) begin
      ctr_q[upd_idx] <= ctr_next(ctr_q[upd_idx], upd_taken);
    end else begin
      ctr_q[upd_idx] <= ctr_q[upd_idx];
    end
  end

endmodule

// File: rtl/if_bpred_stage.sv
// Fetch stage: PC register, beq/bne predecode and prediction, IF/ID pipeline register.
module if_bpred_stage
  import rv_pkg::*;
#(
  parameter int          BHT_DEPTH = 16,
  parameter int          BHT_IDX_W = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        if_stall,
  input  logic        jump,
  input  logic [31:0] pc_jump,
  input  logic        br_upd,
  input  logic        br_taken,
  input  logic [31:0] inst_in,
  output logic [31:0] pc_imem,
  output logic [31:0] ins,
  output logic [31:0] pc,
  output logic [31:0] pc_4,
  output logic        BrPre_if
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ins_q, ins_d;
  logic [31:0] idpc_q, idpc_d;
  logic [31:0] idpc4_q, idpc4_d;
  logic        brpre_q, brpre_d;

  logic        is_br_s;
  logic [31:0] b_imm_s;
  logic [1:0]  rd_ctr_s;
  logic        pred_s;
  logic        upd_en_s;
  logic [31:0] pc_plus4_s;

  bht #(
    .BHT_DEPTH(BHT_DEPTH),
    .BHT_IDX_W(BHT_IDX_W)
  ) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (pc_q[BHT_IDX_W+1:2]),
    .rd_ctr   (rd_ctr_s),
    .upd_en   (upd_en_s),
    .upd_idx  (idpc_q[BHT_IDX_W+1:2]),
    .upd_taken(br_taken)
  );

  // Predecode of the fetched word and the resulting taken prediction.
  always_comb begin
    is_br_s    = (inst_in[6:0] == OPC_BRANCH) &&
                 ((inst_in[14:12] == F3_BEQ) || (inst_in[14:12] == F3_BNE));
    b_imm_s    = {{19{inst_in[31]}}, inst_in[31], inst_in[7], inst_in[30:25],
                  inst_in[11:8], 1'b0};
    pred_s     = is_br_s && rd_ctr_s[1];
    pc_plus4_s = pc_q + 32'd4;
    upd_en_s   = br_upd && !stall && !if_stall;
  end

  // Next PC and IF/ID contents; if_stall outranks jump should both ever arrive.
  always_comb begin
    pc_d    = pc_q;
    ins_d   = ins_q;
    idpc_d  = idpc_q;
    idpc4_d = idpc4_q;
    brpre_d = brpre_q;
    if (stall || if_stall) begin
      pc_d = pc_q;
    end else if (jump) begin
      pc_d    = pc_jump;
      ins_d   = NOP_INS;
      idpc_d  = 32'd0;
      idpc4_d = 32'd0;
      brpre_d = 1'b0;
    end else begin
      pc_d    = pred_s ? (pc_q + b_imm_s) : pc_plus4_s;
      ins_d   = inst_in;
      idpc_d  = pc_q;
      idpc4_d = pc_plus4_s;
      brpre_d = pred_s;
    end
  end

  // PC and IF/ID state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      ins_q   <= NOP_INS;
      idpc_q  <= 32'd0;
      idpc4_q <= 32'd0;
      brpre_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      ins_q   <= ins_d;
      idpc_q  <= idpc_d;
      idpc4_q <= idpc4_d;
      brpre_q <= brpre_d;
    end
  end

  assign pc_imem  = pc_q;
  assign ins      = ins_q;
  assign pc       = idpc_q;
  assign pc_4     = idpc4_q;
  assign BrPre_if = brpre_q;

endmodule

// File: tb/tb_if_bpred_stage.sv
// Directed bench for if_bpred_stage with a cycle-level reference model of the fetch rules.
module tb_if_bpred_stage;

  logic        clk = 1'b0;
  logic        rst, stall, if_stall, jump, br_upd, br_taken;
  logic [31:0] pc_jump, inst_in;
  logic [31:0] pc_imem, ins, pc, pc_4;
  logic        BrPre_if;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state
  logic [31:0] m_pc, m_ins, m_idpc, m_idpc4;
  logic        m_bp;
  int          m_bht [16];

  localparam logic [31:0] NOP = 32'h0000_0013;

  if_bpred_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .if_stall(if_stall), .jump(jump),
    .pc_jump(pc_jump), .br_upd(br_upd), .br_taken(br_taken), .inst_in(inst_in),
    .pc_imem(pc_imem), .ins(ins), .pc(pc), .pc_4(pc_4), .BrPre_if(BrPre_if)
  );

  always #5 clk = ~clk;

  // beq +0x20 at 0x10, blt (unpredicted funct3) at 0x50, bne -0x10 at 0x54
  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'h0000_0010: return 32'h0200_0063;
      32'h0000_0050: return 32'h0200_4063;
      32'h0000_0054: return 32'hFE00_18E3;
      default:       return NOP;
    endcase
  endfunction

  assign inst_in = imem(pc_imem);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model predicts the post-edge outputs, then all are compared.
  task automatic step(input logic s, input logic is, input logic j, input logic [31:0] pj,
                      input logic bu, input logic bt);
    logic [31:0] w, imm, n_pc, n_ins, n_idpc, n_idpc4;
    logic        isbr, pr, n_bp;
    int          ui;
    stall = s; if_stall = is; jump = j; pc_jump = pj; br_upd = bu; br_taken = bt;
    w    = imem(m_pc);
    isbr = (w[6:0] == 7'h63) && (w[14:12] == 3'd0 || w[14:12] == 3'd1);
    imm  = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    pr   = isbr && (m_bht[m_pc[5:2]] >= 2);
    n_pc = m_pc; n_ins = m_ins; n_idpc = m_idpc; n_idpc4 = m_idpc4; n_bp = m_bp;
    ui   = int'(m_idpc[5:2]);
    @(posedge clk);
    #1;
    if (rst) begin
      n_pc = 32'd0; n_ins = NOP; n_idpc = 32'd0; n_idpc4 = 32'd0; n_bp = 1'b0;
      for (int i = 0; i < 16; i++) m_bht[i] = 1;
    end else if (!s && !is) begin
      if (bu) m_bht[ui] = bt ? ((m_bht[ui] == 3) ? 3 : m_bht[ui] + 1)
                             : ((m_bht[ui] == 0) ? 0 : m_bht[ui] - 1);
      if (j) begin
        n_pc = pj; n_ins = NOP; n_idpc = 32'd0; n_idpc4 = 32'd0; n_bp = 1'b0;
      end else begin
        n_pc = pr ? m_pc + imm : m_pc + 32'd4;
        n_ins = w; n_idpc = m_pc; n_idpc4 = m_pc + 32'd4; n_bp = pr;
      end
    end
    m_pc = n_pc; m_ins = n_ins; m_idpc = n_idpc; m_idpc4 = n_idpc4; m_bp = n_bp;
    check("pc_imem", pc_imem, m_pc);
    check("ins", ins, m_ins);
    check("pc", pc, m_idpc);
    check("pc_4", pc_4, m_idpc4);
    check("BrPre_if", {31'd0, BrPre_if}, {31'd0, m_bp});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic jmp(input logic [31:0] t);
    step(1'b0, 1'b0, 1'b1, t, 1'b0, 1'b0);
  endtask

  task automatic upd(input logic bt);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, bt);
  endtask

  initial begin
    m_pc = 32'hFFFF_FFFF; m_ins = 32'd0; m_idpc = 32'd0; m_idpc4 = 32'd0; m_bp = 1'b0;
    for (int i = 0; i < 16; i++) m_bht[i] = 0;
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    check("rst_pc_imem", pc_imem, 32'h0);
    check("rst_ins", ins, NOP);
    check("rst_pc4", pc_4, 32'h0);
    rst = 1'b0;

    // Sequential NOP fetch
    run(1);
    check("seq_pc4", pc_4, 32'h4);
    run(3);
    check("seq_pc_imem", pc_imem, 32'h10);

    // beq training over three visits
    run(1);
    check("beq1_next", pc_imem, 32'h14);
    check("beq1_pred", {31'd0, BrPre_if}, 32'd0);
    upd(1'b1);
    jmp(32'h10);
    run(1);
    upd(1'b1);
    jmp(32'h10);
    run(1);
    check("beq3_next", pc_imem, 32'h30);
    check("beq3_pred", {31'd0, BrPre_if}, 32'd1);
    upd(1'b1);

    // blt aliasing a strongly-taken entry is still not predicted
    jmp(32'h50);
    run(1);
    check("blt_next", pc_imem, 32'h54);
    check("blt_pred", {31'd0, BrPre_if}, 32'd0);

    // if_stall holds state and blocks training; only the release update counts
    jmp(32'h10);
    run(1);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
    check("ifst_pc_imem", pc_imem, 32'h30);
    check("ifst_pc", pc, 32'h10);
    check("ifst_pred", {31'd0, BrPre_if}, 32'd1);
    upd(1'b0);
    jmp(32'h10);
    run(1);
    check("ifst_still_taken", pc_imem, 32'h30);
    upd(1'b0);
    jmp(32'h10);
    run(1);
    check("ifst_now_nt", pc_imem, 32'h14);

    // Redirect flushes IF/ID
    jmp(32'h3C);
    run(1);
    jmp(32'h100);
    check("jmp_target", pc_imem, 32'h100);
    check("jmp_flush_ins", ins, NOP);
    check("jmp_flush_pred", {31'd0, BrPre_if}, 32'd0);

    // stall dominates jump and training
    run(1);
    step(1'b1, 1'b0, 1'b1, 32'h200, 1'b1, 1'b1);
    check("stall_hold", pc_imem, 32'h104);
    check("stall_hold_pc", pc, 32'h100);
    jmp(32'h200);
    check("stall_release", pc_imem, 32'h200);

    // Saturation at 00 on the bne entry, then climb back
    for (int k = 0; k < 4; k++) begin
      jmp(32'h54);
      run(1);
      upd(1'b0);
    end
    jmp(32'h54);
    run(1);
    upd(1'b1);
    jmp(32'h54);
    run(1);
    check("sat_pred0", pc_imem, 32'h58);
    check("sat_brpre0", {31'd0, BrPre_if}, 32'd0);
    upd(1'b1);
    jmp(32'h54);
    run(1);
    check("bne_back", pc_imem, 32'h44);

    // Mid-run reset clears PC, IF/ID and the BHT
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    rst = 1'b0;
    check("mrst_pc_imem", pc_imem, 32'h0);
    check("mrst_ins", ins, NOP);
    jmp(32'h54);
    run(1);
    check("mrst_bht", pc_imem, 32'h58);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
